// File: rtl/tag_req_scheduler.sv
// tag_req_scheduler: walks a programmed tile loop, issuing one fresh tag request per tile followed by
// reuse_cnt reuse requests, flags the last store, waits for the tag sync block to drain, then signals
// block_done and done. Define TAG_SCHED_PERF_EN to add the stall_cycles/drain_cycles counters.
module tag_req_scheduler #(
    parameter int NUM_TAGS            = 2,
    parameter int TAG_W               = $clog2(NUM_TAGS),
    parameter int TILE_CNT_W          = 16,
    parameter int TAG_REUSE_COUNTER_W = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [TILE_CNT_W-1:0]          cfg_num_tiles,
    input  logic [TAG_REUSE_COUNTER_W-1:0] cfg_reuse_cnt,
    input  logic                           cfg_bias_prev_sw,
    input  logic                           cfg_ddr_pe_sw,
    output logic                           busy,
    output logic                           done,
    output logic                           tag_req,
    output logic                           tag_reuse,
    output logic                           tag_bias_prev_sw,
    output logic                           tag_ddr_pe_sw,
    input  logic                           tag_ready,
    input  logic [TAG_W-1:0]               tag,
    input  logic                           tag_done,
    output logic                           last_store_en,
    output logic                           block_done,
    output logic                           issue_valid,
    output logic [TAG_W-1:0]               issue_tag,
`ifdef TAG_SCHED_PERF_EN
    output logic [TILE_CNT_W-1:0]          tile_idx,
    output logic [31:0]                    stall_cycles,
    output logic [31:0]                    drain_cycles
`else
    output logic [TILE_CNT_W-1:0]          tile_idx
`endif
);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN, FIN} state_t;

    state_t                         state, state_nxt;
    logic [TILE_CNT_W-1:0]          num_tiles;
    logic [TAG_REUSE_COUNTER_W-1:0] reuse_cnt, req_idx;
    logic                           bias_prev_sw, ddr_pe_sw;
    logic                           launch, accept, last_req;

    assign last_req = (tile_idx == num_tiles - TILE_CNT_W'(1)) && (req_idx == reuse_cnt);

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state decode and request-side outputs; tag_req is gated by reset so it drops at once
    always_comb begin
        state_nxt        = state;
        busy             = 1'b0;
        tag_req          = 1'b0;
        tag_reuse        = 1'b0;
        tag_bias_prev_sw = 1'b0;
        tag_ddr_pe_sw    = 1'b0;
        accept           = 1'b0;
        issue_valid      = 1'b0;
        issue_tag        = '0;
        launch           = 1'b0;
        case (state)
            IDLE: begin
                launch = start;
                if (start) state_nxt = (cfg_num_tiles == '0) ? FIN : REQ;
            end
            REQ: begin
                busy             = 1'b1;
                tag_req          = !reset;
                tag_reuse        = tag_req && (req_idx != '0);
                tag_bias_prev_sw = tag_req && bias_prev_sw && (tile_idx != '0);
                tag_ddr_pe_sw    = tag_req && ddr_pe_sw;
                accept           = tag_req && tag_ready;
                issue_valid      = accept;
                issue_tag        = accept ? tag : '0;
                if (abort)                  state_nxt = IDLE;
                else if (accept && last_req) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (abort)         state_nxt = IDLE;
                else if (tag_done) state_nxt = FIN;
            end
            default: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // latched configuration and tile/request counters; abort wins over a same-cycle accept
    always_ff @(posedge clk) begin
        if (reset) begin
            num_tiles    <= '0;
            reuse_cnt    <= '0;
            bias_prev_sw <= 1'b0;
            ddr_pe_sw    <= 1'b0;
            tile_idx     <= '0;
            req_idx      <= '0;
        end else if (launch) begin
            num_tiles    <= cfg_num_tiles;
            reuse_cnt    <= cfg_reuse_cnt;
            bias_prev_sw <= cfg_bias_prev_sw;
            ddr_pe_sw    <= cfg_ddr_pe_sw;
            tile_idx     <= '0;
            req_idx      <= '0;
        end else if (accept && !abort) begin
            req_idx  <= (req_idx == reuse_cnt) ? '0 : req_idx + TAG_REUSE_COUNTER_W'(1);
            tile_idx <= (req_idx == reuse_cnt) ? tile_idx + TILE_CNT_W'(1) : tile_idx;
        end
    end

    // registered one-cycle completion pulses, suppressed by abort
    always_ff @(posedge clk) begin
        if (reset) begin
            last_store_en <= 1'b0;
            block_done    <= 1'b0;
            done          <= 1'b0;
        end else begin
            last_store_en <= accept && last_req && !abort;
            block_done    <= (state == DRAIN) && tag_done && !abort;
            done          <= (state == FIN) && !abort;
        end
    end

`ifdef TAG_SCHED_PERF_EN
    // saturating counters of stalled request cycles and drain cycles, cleared by a launch
    always_ff @(posedge clk) begin
        if (reset || launch) begin
            stall_cycles <= '0;
            drain_cycles <= '0;
        end else begin
            if (state == REQ && !tag_ready && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
            if (state == DRAIN && drain_cycles != '1)              drain_cycles <= drain_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tag_req_scheduler.sv
// tb_tag_req_scheduler: randomized self-checking bench for tag_req_scheduler against a request-list model.
module tb_tag_req_scheduler;
    localparam int TAG_W = 1;
    localparam int TW    = 16;
    localparam int RW    = 3;

    logic            clk = 1'b0;
    logic            reset, start, abort, cfg_bias_prev_sw, cfg_ddr_pe_sw, tag_ready, tag_done;
    logic [TW-1:0]   cfg_num_tiles;
    logic [RW-1:0]   cfg_reuse_cnt;
    logic [TAG_W-1:0] tag;
    logic            busy, done, tag_req, tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw;
    logic            last_store_en, block_done, issue_valid;
    logic [TAG_W-1:0] issue_tag;
    logic [TW-1:0]   tile_idx;
`ifdef TAG_SCHED_PERF_EN
    logic [31:0]     stall_cycles, drain_cycles;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    tag_req_scheduler #(.NUM_TAGS(2), .TILE_CNT_W(TW), .TAG_REUSE_COUNTER_W(RW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_num_tiles(cfg_num_tiles), .cfg_reuse_cnt(cfg_reuse_cnt),
        .cfg_bias_prev_sw(cfg_bias_prev_sw), .cfg_ddr_pe_sw(cfg_ddr_pe_sw),
        .busy(busy), .done(done), .tag_req(tag_req), .tag_reuse(tag_reuse),
        .tag_bias_prev_sw(tag_bias_prev_sw), .tag_ddr_pe_sw(tag_ddr_pe_sw),
        .tag_ready(tag_ready), .tag(tag), .tag_done(tag_done),
        .last_store_en(last_store_en), .block_done(block_done),
        .issue_valid(issue_valid), .issue_tag(issue_tag),
`ifdef TAG_SCHED_PERF_EN
        .stall_cycles(stall_cycles), .drain_cycles(drain_cycles),
`endif
        .tile_idx(tile_idx));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // one full block: the model is the ordered list of requests, request k belonging to tile k/(rc+1)
    task automatic run_block(input int n, input int rc, input bit b, input bit d, input int pct, input int hold);
        int total, acc, cyc, stalls;
        logic [TW-1:0] et;
        bit er;
        total = n * (rc + 1);
        acc = 0; cyc = 0; stalls = 0;
        cfg_num_tiles = TW'(n); cfg_reuse_cnt = RW'(rc);
        cfg_bias_prev_sw = b; cfg_ddr_pe_sw = d;
        start = 1'b1; tag_done = 1'b0; tag_ready = 1'b0; abort = 1'b0;
        #2;
        checks++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else passed++;
        tick;
        start = 1'b0;
        while (acc < total && cyc < 400) begin
            tag_ready = ($urandom_range(0, 99) < pct);
            tag = TAG_W'($urandom);
            et = TW'(acc / (rc + 1));
            er = (acc % (rc + 1)) != 0;
            #2;
            checks++;
            if ({busy, tag_req, tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw, tile_idx, issue_valid, last_store_en, block_done, done}
                !== {1'b1, 1'b1, er, b && (et != '0), d, et, tag_ready, 3'b000})
                $display("FAIL req%0d got busy=%b req=%b reuse=%b bias=%b ddr=%b tile=%0d iv=%b lse=%b bd=%b done=%b want reuse=%b bias=%b ddr=%b tile=%0d iv=%b",
                         acc, busy, tag_req, tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw, tile_idx, issue_valid,
                         last_store_en, block_done, done, er, b && (et != '0), d, et, tag_ready);
            else passed++;
            if (tag_ready) begin
                checks++; if (issue_tag !== tag) $display("FAIL issue_tag got %0d want %0d", issue_tag, tag); else passed++;
                acc++;
            end else stalls++;
            tick;
            cyc++;
        end
        tag_ready = 1'b0;
        checks++; if (acc != total) $display("FAIL req_budget accepts %0d want %0d", acc, total); else passed++;
        if (pct >= 100) begin
            checks++; if (cyc != total) $display("FAIL back_to_back cycles %0d want %0d", cyc, total); else passed++;
        end
        if (total > 0) begin
            for (int k = 0; k <= hold; k++) begin
                tag_done = (k == hold);
                #2;
                checks++;
                if ({busy, tag_req, issue_valid, last_store_en, block_done, done} !== {1'b1, 1'b0, 1'b0, k == 0, 1'b0, 1'b0})
                    $display("FAIL drain%0d got busy=%b req=%b iv=%b lse=%b bd=%b done=%b want lse=%b", k,
                             busy, tag_req, issue_valid, last_store_en, block_done, done, k == 0);
                else passed++;
                tick;
            end
            tag_done = 1'b0;
            #2;
            checks++;
            if ({block_done, done, last_store_en, tag_req} !== 4'b1000)
                $display("FAIL block_done got bd=%b done=%b lse=%b req=%b want 1000", block_done, done, last_store_en, tag_req);
            else passed++;
        end else begin
            #2;
            checks++;
            if ({tag_req, done, last_store_en, block_done} !== 4'b0000)
                $display("FAIL zero_fin got req=%b done=%b lse=%b bd=%b want 0000", tag_req, done, last_store_en, block_done);
            else passed++;
        end
        tick;
        #2;
        checks++;
        if ({done, busy, block_done, tag_req} !== 4'b1000)
            $display("FAIL done_pulse got done=%b busy=%b bd=%b req=%b want 1000", done, busy, block_done, tag_req);
        else passed++;
        tick;
        #2;
        checks++; if ({done, busy} !== 2'b00) $display("FAIL done_end got done=%b busy=%b want 00", done, busy); else passed++;
`ifdef TAG_SCHED_PERF_EN
        checks++; if (stall_cycles !== 32'(stalls)) $display("FAIL stall_cycles got %0d want %0d", stall_cycles, stalls); else passed++;
        checks++;
        if (drain_cycles !== 32'(total > 0 ? hold + 1 : 0)) $display("FAIL drain_cycles got %0d want %0d", drain_cycles, total > 0 ? hold + 1 : 0);
        else passed++;
`endif
    endtask

    task automatic test_reset;
        reset = 1'b1; tag_ready = 1'b1;
        tick; tick;
        #2;
        checks++;
        if ({busy, done, tag_req, tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw, last_store_en, block_done, issue_valid, issue_tag, tile_idx} !== '0)
            $display("FAIL reset_outputs got busy=%b done=%b req=%b lse=%b bd=%b iv=%b tile=%0d want all 0",
                     busy, done, tag_req, last_store_en, block_done, issue_valid, tile_idx);
        else passed++;
        reset = 1'b0; tag_ready = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        run_block(3, 0, 1'b0, 1'b0, 100, 0);
        run_block(3, 0, 1'b1, 1'b1, 100, 2);
    endtask

    task automatic test_reuse;
        run_block(2, 2, 1'b1, 1'b0, 100, 1);
        run_block(2, 2, 1'b0, 1'b1, 60, 0);
        run_block(1, 7, 1'b1, 1'b1, 80, 3);
    endtask

    task automatic test_stall;
        cfg_num_tiles = 16'd2; cfg_reuse_cnt = 3'd1; cfg_bias_prev_sw = 1'b1; cfg_ddr_pe_sw = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tag_ready = 1'b0;
            start = (k == 2);
            cfg_reuse_cnt = (k == 2) ? 3'd5 : 3'd1;
            #2;
            checks++;
            if ({tag_req, tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw, issue_valid, tile_idx} !== {5'b10010, 16'd0})
                $display("FAIL stall%0d got req=%b reuse=%b bias=%b ddr=%b iv=%b tile=%0d want 10010 tile 0",
                         k, tag_req, tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw, issue_valid, tile_idx);
            else passed++;
            tick;
        end
        start = 1'b0; cfg_reuse_cnt = 3'd1; tag_ready = 1'b1;
        #2;
        checks++; if ({issue_valid, tag_reuse} !== 2'b10) $display("FAIL stall_release got iv=%b reuse=%b want 10", issue_valid, tag_reuse); else passed++;
`ifdef TAG_SCHED_PERF_EN
        checks++; if (stall_cycles !== 32'd5) $display("FAIL stall_count got %0d want 5", stall_cycles); else passed++;
`endif
        tick;
        #2;
        checks++; if ({issue_valid, tag_reuse} !== 2'b11) $display("FAIL stall_reuse got iv=%b reuse=%b want 11", issue_valid, tag_reuse); else passed++;
        tick;
        abort = 1'b1;
        #2;
        checks++;
        if ({tile_idx, tag_bias_prev_sw, tag_reuse} !== {16'd1, 2'b10})
            $display("FAIL busy_start_ignored got tile=%0d bias=%b reuse=%b want tile 1 bias 1 reuse 0", tile_idx, tag_bias_prev_sw, tag_reuse);
        else passed++;
        tick;
        abort = 1'b0; tag_ready = 1'b0;
        #2;
        checks++; if ({tag_req, busy} !== 2'b00) $display("FAIL stall_abort got req=%b busy=%b want 00", tag_req, busy); else passed++;
        tick;
        #2;
        checks++;
        if ({done, block_done, last_store_en} !== 3'b000) $display("FAIL stall_abort_pulses got done=%b bd=%b lse=%b want 000", done, block_done, last_store_en);
        else passed++;
    endtask

    task automatic test_zero_tiles;
        run_block(0, 3, 1'b1, 1'b1, 100, 0);
    endtask

    task automatic test_abort;
        cfg_num_tiles = 16'd4; cfg_reuse_cnt = 3'd0; cfg_bias_prev_sw = 1'b0; cfg_ddr_pe_sw = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0; tag_ready = 1'b1; tag = 1'b1;
        #2;
        checks++; if ({issue_valid, tile_idx} !== {1'b1, 16'd0}) $display("FAIL abort_acc1 got iv=%b tile=%0d want 1 0", issue_valid, tile_idx); else passed++;
        tick;
        abort = 1'b1;
        #2;
        checks++; if ({issue_valid, tile_idx} !== {1'b1, 16'd1}) $display("FAIL abort_acc2 got iv=%b tile=%0d want 1 1", issue_valid, tile_idx); else passed++;
        tick;
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            checks++;
            if ({busy, tag_req, issue_valid, done, block_done, last_store_en, tile_idx} !== {6'b000000, 16'd1})
                $display("FAIL abort_idle%0d got busy=%b req=%b iv=%b done=%b bd=%b lse=%b tile=%0d want 0s tile 1",
                         k, busy, tag_req, issue_valid, done, block_done, last_store_en, tile_idx);
            else passed++;
            tick;
        end
        tag_ready = 1'b0;
        run_block(4, 0, 1'b0, 1'b0, 100, 1);
    endtask

    task automatic test_reset_in_drain;
        cfg_num_tiles = 16'd1; cfg_reuse_cnt = 3'd0;
        start = 1'b1;
        tick;
        start = 1'b0; tag_ready = 1'b1;
        tick;
        tag_ready = 1'b0;
        #2;
        checks++; if ({last_store_en, busy, tag_req} !== 3'b110) $display("FAIL drain_entry got lse=%b busy=%b req=%b want 110", last_store_en, busy, tag_req); else passed++;
        reset = 1'b1;
        tick;
        #2;
        checks++;
        if ({busy, done, tag_req, last_store_en, block_done, issue_valid, tile_idx} !== '0)
            $display("FAIL drain_reset got busy=%b done=%b req=%b lse=%b bd=%b iv=%b tile=%0d want all 0",
                     busy, done, tag_req, last_store_en, block_done, issue_valid, tile_idx);
        else passed++;
        reset = 1'b0;
        tick;
        run_block(1, 0, 1'b1, 1'b1, 70, 2);
    endtask

    task automatic test_random(input int runs);
        for (int r = 0; r < runs; r++)
            run_block($urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                      $urandom_range(30, 100), $urandom_range(0, 3));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; tag_ready = 1'b0; tag_done = 1'b0; tag = '0;
        cfg_num_tiles = '0; cfg_reuse_cnt = '0; cfg_bias_prev_sw = 1'b0; cfg_ddr_pe_sw = 1'b0;
        test_reset;
        test_basic;
        test_reuse;
        test_stall;
        test_zero_tiles;
        test_abort;
        test_reset_in_drain;
        test_random(25);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
